// File: rtl/desired_drive_pkg.sv
// Shared constants for the desired_drive motor-current pipeline.
// TORQUE_MIN_DEFAULT is the torque offset below which no assist is produced;
// the *_W constants fix the widths of the intermediate factors and the
// final assist product so every stage stays overflow-free.
package desired_drive_pkg;

  localparam logic [11:0] TORQUE_MIN_DEFAULT = 12'h380;

  localparam int unsigned TORQUE_W         = 12;
  localparam int unsigned INCLINE_W        = 13;
  localparam int unsigned INCLINE_SAT_W    = 10;
  localparam int unsigned INCLINE_LIM_W    = 9;
  localparam int unsigned CADENCE_W        = 5;
  localparam int unsigned CADENCE_FACTOR_W = 6;
  localparam int unsigned SCALE_W          = 3;
  localparam int unsigned PROD_TC_W        = TORQUE_W + CADENCE_FACTOR_W;   // 18
  localparam int unsigned PROD_IS_W        = INCLINE_LIM_W + SCALE_W;       // 12
  localparam int unsigned ASSIST_PROD_W    = PROD_TC_W + PROD_IS_W;         // 30

endpackage

// File: rtl/desired_drive_factors.sv
// Combinational front end of desired_drive.
// Ports:
//   avg_torque     in  12  unsigned averaged crank torque
//   cadence        in  5   unsigned cadence measure
//   incline        in  13  signed incline
//   incline_lim    out 9   incline term, limited to 0..511
//   cadence_factor out 6   cadence + 32, or 0 when cadence <= 1
//   torque_pos     out 12  avg_torque - TORQUE_MIN, floored at 0
module desired_drive_factors
  import desired_drive_pkg::*;
#(
  parameter logic [11:0] TORQUE_MIN = TORQUE_MIN_DEFAULT
) (
  input  logic [TORQUE_W-1:0]         avg_torque,
  input  logic [CADENCE_W-1:0]        cadence,
  input  logic [INCLINE_W-1:0]        incline,
  output logic [INCLINE_LIM_W-1:0]    incline_lim,
  output logic [CADENCE_FACTOR_W-1:0] cadence_factor,
  output logic [TORQUE_W-1:0]         torque_pos
);

  logic [INCLINE_SAT_W-1:0] incline_sat;
  logic [INCLINE_SAT_W:0]   incline_factor;
  logic [TORQUE_W:0]        torque_off;

  always_comb begin
    if ($signed(incline) > 13'sd511) begin
      incline_sat = 10'h1FF;
    end else if ($signed(incline) < -13'sd512) begin
      incline_sat = 10'h200;
    end else begin
      incline_sat = incline[INCLINE_SAT_W-1:0];
    end

    // Factor spans -256..767: bit 10 flags negative, bit 9 flags > 511.
    incline_factor = {incline_sat[INCLINE_SAT_W-1], incline_sat} + 11'd256;
    if (incline_factor[INCLINE_SAT_W]) begin
      incline_lim = '0;
    end else if (incline_factor[INCLINE_SAT_W-1]) begin
      incline_lim = '1;
    end else begin
      incline_lim = incline_factor[INCLINE_LIM_W-1:0];
    end
  end

  always_comb begin
    if (cadence > 5'd1) begin
      cadence_factor = {1'b0, cadence} + 6'd32;
    end else begin
      cadence_factor = '0;
    end
  end

  always_comb begin
    torque_off = {1'b0, avg_torque} - {1'b0, TORQUE_MIN};
    if (torque_off[TORQUE_W]) begin
      torque_pos = '0;
    end else begin
      torque_pos = torque_off[TORQUE_W-1:0];
    end
  end

endmodule

// File: rtl/desired_drive.sv
// Desired motor current for the e-bike assist controller.
// Two-stage multiplier pipeline: inputs applied after rising edge N appear
// on target_curr after rising edge N+2; one new input set per cycle.
// Ports:
//   clk          in  1   system clock, rising edge
//   rst_n        in  1   synchronous active-low reset
//   avg_torque   in  12  unsigned averaged crank torque
//   cadence      in  5   unsigned cadence measure
//   not_pedaling in  1   1 forces zero assist
//   incline      in  13  signed incline
//   scale        in  3   assist level 0..7
//   target_curr  out 12  desired motor current, saturates at 12'hFFF
module desired_drive
  import desired_drive_pkg::*;
#(
  parameter logic [11:0] TORQUE_MIN = TORQUE_MIN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TORQUE_W-1:0]  avg_torque,
  input  logic [CADENCE_W-1:0] cadence,
  input  logic                 not_pedaling,
  input  logic [INCLINE_W-1:0] incline,
  input  logic [SCALE_W-1:0]   scale,
  output logic [11:0]          target_curr
);

  logic [INCLINE_LIM_W-1:0]    incline_lim;
  logic [CADENCE_FACTOR_W-1:0] cadence_factor;
  logic [TORQUE_W-1:0]         torque_pos;

  logic [PROD_TC_W-1:0]        prod_tc;
  logic [PROD_IS_W-1:0]        prod_is;
  logic                        np_q;
  logic [ASSIST_PROD_W-1:0]    assist_prod;
  logic                        unused_lsbs;

  desired_drive_factors #(
    .TORQUE_MIN (TORQUE_MIN)
  ) u_factors (
    .avg_torque     (avg_torque),
    .cadence        (cadence),
    .incline        (incline),
    .incline_lim    (incline_lim),
    .cadence_factor (cadence_factor),
    .torque_pos     (torque_pos)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_tc     <= '0;
      prod_is     <= '0;
      np_q        <= 1'b0;
      assist_prod <= '0;
    end else begin
      prod_tc     <= PROD_TC_W'(torque_pos) * PROD_TC_W'(cadence_factor);
      prod_is     <= PROD_IS_W'(incline_lim) * PROD_IS_W'(scale);
      np_q        <= not_pedaling;
      assist_prod <= np_q ? '0
                          : ASSIST_PROD_W'(prod_tc) * ASSIST_PROD_W'(prod_is);
    end
  end

  assign target_curr = (|assist_prod[29:27]) ? 12'hFFF : assist_prod[26:15];

  // Fractional bits below the output scaling are intentionally discarded.
  assign unused_lsbs = ^assist_prod[14:0];

endmodule

// File: tb/tb_desired_drive.sv
module tb_desired_drive;

  localparam int TMIN = 896;  // 12'h380

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] avg_torque;
  logic [4:0]  cadence;
  logic        not_pedaling;
  logic [12:0] incline;
  logic [2:0]  scale;
  logic [11:0] target_curr;

  typedef struct {
    int exp;
    int due;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   done  = 0;

  desired_drive dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .avg_torque   (avg_torque),
    .cadence      (cadence),
    .not_pedaling (not_pedaling),
    .incline      (incline),
    .scale        (scale),
    .target_curr  (target_curr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model(int at, int cad, bit np, int inc, int sc);
    longint t, c, f, p;
    if (np) return 0;
    t = at - TMIN;
    if (t < 0) t = 0;
    c = (cad > 1) ? cad + 32 : 0;
    if (inc > 511) inc = 511;
    if (inc < -512) inc = -512;
    f = inc + 256;
    if (f < 0) f = 0;
    if (f > 511) f = 511;
    p = (t * c * f * sc) / 32768;
    if (p > 4095) p = 4095;
    return int'(p);
  endfunction

  // inc is a signed integer in -4096..4095.
  task automatic drive(string name, bit rst, int at, int cad, bit np, int inc, int sc);
    exp_t e;
    logic [12:0] inc13;
    @(posedge clk);
    #1;
    inc13        = inc[12:0];
    rst_n        = ~rst;
    avg_torque   = at[11:0];
    cadence      = cad[4:0];
    not_pedaling = np;
    incline      = inc13;
    scale        = sc[2:0];
    // A reset at the coming edge also wipes the set already in flight.
    if (rst && q.size() > 0 && q[$].due == cyc + 1) begin
      e = q.pop_back();
      e.exp = 0;
      q.push_back(e);
    end
    e.exp  = rst ? 0 : model(at, cad, np, int'($signed(inc13)), sc);
    e.due  = cyc + 2;
    e.name = name;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      total++;
      bad++;
      $display("FAIL %s: expected result due at cycle %0d never checked", q[0].name, q[0].due);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (target_curr !== e.exp[11:0]) begin
        bad++;
        $display("FAIL %s: cycle %0d target_curr=%h required=%h", e.name, cyc, target_curr, e.exp[11:0]);
      end
    end
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; avg_torque = '0; cadence = '0; not_pedaling = 1'b0;
    incline = '0; scale = '0;
    e.exp = 0; e.name = "reset";
    e.due = 1; q.push_back(e);
    e.due = 2; q.push_back(e);

    repeat (3) drive("reset", 1, 12'h800, 16, 0, 0, 3);

    drive("vec1", 0, 12'h800, 16, 0, 0, 3);
    drive("vec2_sat", 0, 12'hFFF, 31, 0, 511, 7);
    drive("np", 0, 12'h800, 16, 1, 0, 3);
    drive("torque_low", 0, 12'h300, 16, 0, 0, 3);
    drive("torque_eq_min", 0, 12'h380, 16, 0, 0, 3);
    drive("torque_min_p1", 0, 12'h381, 31, 0, 511, 7);
    drive("cad1", 0, 12'h800, 1, 0, 0, 3);
    drive("cad0", 0, 12'h800, 0, 0, 0, 3);
    drive("cad2", 0, 12'h800, 2, 0, 0, 3);
    drive("scale0", 0, 12'h800, 16, 0, 0, 0);
    drive("inc_m300", 0, 12'h800, 16, 0, -300, 3);
    drive("inc_m257", 0, 12'h800, 16, 0, -257, 3);
    drive("inc_m256", 0, 12'h800, 16, 0, -256, 3);
    drive("inc_min", 0, 12'h800, 16, 0, -4096, 3);
    drive("inc_256", 0, 12'h800, 16, 0, 256, 3);
    drive("inc_4000", 0, 12'h800, 16, 0, 4000, 3);
    drive("inc_255", 0, 12'h800, 16, 0, 255, 3);

    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive("pipe_v1", 0, 12'h800, 16, 0, 0, 3);
      else            drive("pipe_v2", 0, 12'hFFF, 31, 0, 511, 7);
    end

    drive("pre_rst_a", 0, 12'h800, 16, 0, 256, 3);
    drive("pre_rst_b", 0, 12'h800, 16, 0, 0, 3);
    drive("mid_rst", 1, 12'hFFF, 31, 0, 511, 7);
    drive("post_rst1", 0, 12'h800, 16, 0, 0, 3);
    drive("post_rst2", 0, 12'h800, 16, 0, 256, 3);

    for (int i = 0; i < 400; i++) begin
      int at, cad, inc, sc;
      bit np, rst;
      at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(800, 1000)) : int'($urandom_range(0, 4095));
      cad = $urandom_range(0, 31);
      np  = ($urandom_range(0, 7) == 0);
      inc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1200)) - 600
                                        : int'($urandom_range(0, 8191)) - 4096;
      sc  = $urandom_range(0, 7);
      rst = ($urandom_range(0, 29) == 0);
      drive("random", rst, at, cad, np, inc, sc);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
